periph_arb: RTL and testbench

Round-robin arbiter that shares one peripheral core's simple register bus (addr/we/re/wd/rd, as used by the uart core) between NREQ requesters, such as the AHB bridge and a local DMA/streaming engine. It grants at most one transfer per cycle, registers the winning command toward the slave, and returns a one-cycle acknowledge with read data to the winner. It also provides a lock that lets a requester keep exclusive ownership for multi-access sequences, such as status-poll-then-write.

---
 rtl/periph_arb_pkg.sv | 26 ++
 rtl/periph_arb_if.sv | 60 ++++++
 rtl/periph_arb_rr_pick.sv | 40 ++++
 rtl/reg_we.sv | 27 ++
 rtl/periph_arb.sv | 128 ++++++++++++
 tb/tb_periph_arb.sv | 209 ++++++++++++++++++++
 6 files changed

// File: rtl/periph_arb_pkg.sv
// rtl/periph_arb_pkg.sv - shared constants and helpers for the peripheral bus arbiter
//
// Purpose : sizing constants for the requester index and a one-hot to
//           binary index converter used by the round-robin picker.
// Contents: MAX_NREQ  - largest supported requester count
//           IDX_W     - width of a requester index (covers MAX_NREQ)
//           onehot_to_idx() - one-hot vector to binary index

package periph_arb_pkg;

  localparam int MAX_NREQ = 8;
  localparam int IDX_W    = 3;

  // An all-zero input maps to index 0; callers qualify with their own 'any'.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/periph_arb_if.sv
// rtl/periph_arb_if.sv - requester-side and slave-side bus interfaces of the arbiter
//
// periph_arb_req_if : requesters <-> arbiter
//   req, lock, req_we   per-requester request, lock and write flag
//   req_addr, req_wd    packed address / write data, requester i at [i*W +: W]
//   gnt                 one-hot combinational grant
//   ack                 one-hot registered completion
//   rdata               read data, valid with ack of a read
//   modport master = requester side, modport slave = arbiter side
//
// periph_arb_bus_if : arbiter <-> peripheral core register bus
//   s_addr, s_we, s_re, s_wd   registered command toward the core
//   s_rd                       read data, combinational from s_addr
//   modport master = arbiter side, modport slave = peripheral side

interface periph_arb_req_if #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wd;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;

  modport master (
    output req, lock, req_we, req_addr, req_wd,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, lock, req_we, req_addr, req_wd,
    output gnt, ack, rdata
  );
endinterface

interface periph_arb_bus_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic          s_re;
  logic [DW-1:0] s_wd;
  logic [DW-1:0] s_rd;

  modport master (
    output s_addr, s_we, s_re, s_wd,
    input  s_rd
  );

  modport slave (
    input  s_addr, s_we, s_re, s_wd,
    output s_rd
  );
endinterface

// File: rtl/periph_arb_rr_pick.sv
// rtl/periph_arb_rr_pick.sv - combinational round-robin priority picker
//
// Ports: req  - request vector
//        mask - eligibility mask, a request only competes when its bit is set
//        ptr  - requester index where the search starts (wraps mod N)
//        gnt  - one-hot grant to the first eligible request at or after ptr
//        idx  - binary index of the grant (0 when any = 0)
//        any  - some request was granted

module rr_pick
  import periph_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Outer loop walks priority order starting at ptr; inner loop keeps every
  // bit select at a constant index so the search maps to a plain mux tree.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any && req[i] && mask[i] && (((int'(ptr) + k) % N) == i)) begin
          gnt[i] = 1'b1;
          any    = 1'b1;
        end
      end
    end
  end

  assign idx = onehot_to_idx(MAX_NREQ'(gnt));

endmodule

// File: rtl/reg_we.sv
// rtl/reg_we.sv - register cell with write enable and asynchronous active-low clear
//
// Ports: clk  - clock
//        rstn - asynchronous active-low clear, q goes to 0
//        we   - load enable
//        d    - next value
//        q    - registered value

module reg_we #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/periph_arb.sv
// rtl/periph_arb.sv - round-robin arbiter sharing one peripheral register bus between NREQ requesters
//
// Ports: clk  - clock
//        rstn - asynchronous active-low reset
//        rq   - requester side (periph_arb_req_if.slave): req/lock/req_we/
//               req_addr/req_wd in, gnt (combinational), ack (registered),
//               rdata out
//        bus  - peripheral side (periph_arb_bus_if.master): registered
//               s_addr/s_we/s_re/s_wd out, s_rd in
//
// One transfer is accepted per cycle. The winner's command is registered
// toward the core and acked in the following cycle, where rdata carries
// the core's read data. A granted transfer with lock set keeps ownership
// for that requester until it presents lock = 0.

module periph_arb
  import periph_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input logic               clk,
  input logic               rstn,
  periph_arb_req_if.slave   rq,
  periph_arb_bus_if.master  bus
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] win_idx;
  logic             locked_q;
  logic             locked_d;
  logic             lock_held;
  logic             ptr_we;
  logic             any;
  logic             win_we;
  logic             win_lock;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_wd;
  logic [NREQ-1:0]  elig_mask;
  logic [NREQ-1:0]  gnt;

  // The lock only binds while the owner keeps lock high; once it drops,
  // this very cycle is already arbitrated unmasked.
  always_comb begin
    lock_held = 1'b0;
    elig_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        lock_held = locked_q & rq.lock[i];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      elig_mask[i] = !lock_held || (owner_q == IDX_W'(i));
    end
  end

  rr_pick #(
    .N (NREQ)
  ) u_pick (
    .req  (rq.req),
    .mask (elig_mask),
    .ptr  (ptr_q),
    .gnt  (gnt),
    .idx  (win_idx),
    .any  (any)
  );

  // Winner's command fields, selected by the one-hot grant.
  always_comb begin
    win_addr = '0;
    win_wd   = '0;
    win_we   = 1'b0;
    win_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_addr = rq.req_addr[i*AW +: AW];
        win_wd   = rq.req_wd[i*DW +: DW];
        win_we   = rq.req_we[i];
        win_lock = rq.lock[i];
      end
    end
  end

  // Rotation happens only on an unlocked grant, so a locking requester
  // keeps its place in the order when it later releases.
  assign ptr_d    = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
  assign ptr_we   = any & ~win_lock;
  assign locked_d = any ? win_lock : lock_held;

  assign rq.gnt   = gnt;
  assign rq.rdata = bus.s_rd;

  reg_we #(.W(AW)) u_s_addr (
    .clk (clk), .rstn (rstn), .we (any), .d (win_addr), .q (bus.s_addr)
  );

  reg_we #(.W(DW)) u_s_wd (
    .clk (clk), .rstn (rstn), .we (any), .d (win_wd), .q (bus.s_wd)
  );

  reg_we #(.W(1)) u_s_we (
    .clk (clk), .rstn (rstn), .we (1'b1), .d (any & win_we), .q (bus.s_we)
  );

  reg_we #(.W(1)) u_s_re (
    .clk (clk), .rstn (rstn), .we (1'b1), .d (any & ~win_we), .q (bus.s_re)
  );

  reg_we #(.W(NREQ)) u_ack (
    .clk (clk), .rstn (rstn), .we (1'b1), .d (gnt), .q (rq.ack)
  );

  reg_we #(.W(IDX_W)) u_ptr (
    .clk (clk), .rstn (rstn), .we (ptr_we), .d (ptr_d), .q (ptr_q)
  );

  reg_we #(.W(1)) u_locked (
    .clk (clk), .rstn (rstn), .we (1'b1), .d (locked_d), .q (locked_q)
  );

  reg_we #(.W(IDX_W)) u_owner (
    .clk (clk), .rstn (rstn), .we (any), .d (win_idx), .q (owner_q)
  );

endmodule

// File: tb/tb_periph_arb.sv
// tb/tb_periph_arb.sv - self-checking bench for periph_arb

module tb_periph_arb;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  periph_arb_req_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) rq ();
  periph_arb_bus_if #(.AW(AW), .DW(DW)) bus ();

  periph_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .rq   (rq),
    .bus  (bus)
  );

  function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
    return (a == 5'h08) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {27'd0, a});
  endfunction

  assign bus.s_rd = slave_rd(bus.s_addr);

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    rq.req      = r;
    rq.lock     = l;
    rq.req_we   = w;
    rq.req_addr = {a1, a0};
    rq.req_wd   = {d1, d0};
  endtask

  typedef struct {
    logic [1:0]  req, lock, we;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  gnt, ack;
    logic        s_we, s_re;
    logic [4:0]  s_addr;
    logic [31:0] s_wd, rd;
  } vec_t;

  vec_t vecs[17];

  // Reference model state for the random phase
  int           m_ptr, m_owner;
  bit           m_locked;
  logic [AW-1:0] m_saddr;
  logic [DW-1:0] m_swd;

  logic [1:0]    cr, cl, cw;
  logic [AW-1:0] ca[2];
  logic [DW-1:0] cd[2];

  initial begin
    // Directed sequence from reset: write, idle, read, contention, lock, stall, starve
    vecs[0]  = '{2'b01, 2'b00, 2'b01, 5'h04, 5'h00, 32'h41, 32'h0, 2'b01, 2'b01, 1'b1, 1'b0, 5'h04, 32'h41, 32'h0};
    vecs[1]  = '{2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 5'h04, 32'h41, 32'h0};
    vecs[2]  = '{2'b10, 2'b00, 2'b00, 5'h00, 5'h08, 32'h0, 32'h0, 2'b10, 2'b10, 1'b0, 1'b1, 5'h08, 32'h0, 32'hDEAD_BEEF};
    vecs[3]  = '{2'b11, 2'b00, 2'b11, 5'h01, 5'h02, 32'hA0, 32'hB1, 2'b01, 2'b01, 1'b1, 1'b0, 5'h01, 32'hA0, 32'h0};
    vecs[4]  = '{2'b11, 2'b00, 2'b11, 5'h01, 5'h02, 32'hA0, 32'hB1, 2'b10, 2'b10, 1'b1, 1'b0, 5'h02, 32'hB1, 32'h0};
    vecs[5]  = '{2'b11, 2'b00, 2'b11, 5'h01, 5'h02, 32'hA0, 32'hB1, 2'b01, 2'b01, 1'b1, 1'b0, 5'h01, 32'hA0, 32'h0};
    vecs[6]  = '{2'b11, 2'b00, 2'b11, 5'h01, 5'h02, 32'hA0, 32'hB1, 2'b10, 2'b10, 1'b1, 1'b0, 5'h02, 32'hB1, 32'h0};
    vecs[7]  = '{2'b11, 2'b00, 2'b11, 5'h01, 5'h02, 32'hA0, 32'hB1, 2'b01, 2'b01, 1'b1, 1'b0, 5'h01, 32'hA0, 32'h0};
    vecs[8]  = '{2'b11, 2'b00, 2'b11, 5'h01, 5'h02, 32'hA0, 32'hB1, 2'b10, 2'b10, 1'b1, 1'b0, 5'h02, 32'hB1, 32'h0};
    vecs[9]  = '{2'b11, 2'b01, 2'b11, 5'h03, 5'h0C, 32'h1111_0000, 32'h2222_000C, 2'b01, 2'b01, 1'b1, 1'b0, 5'h03, 32'h1111_0000, 32'h0};
    vecs[10] = '{2'b11, 2'b01, 2'b11, 5'h03, 5'h0C, 32'h1111_0000, 32'h2222_000C, 2'b01, 2'b01, 1'b1, 1'b0, 5'h03, 32'h1111_0000, 32'h0};
    vecs[11] = '{2'b11, 2'b00, 2'b11, 5'h03, 5'h0C, 32'h1111_0000, 32'h2222_000C, 2'b01, 2'b01, 1'b1, 1'b0, 5'h03, 32'h1111_0000, 32'h0};
    vecs[12] = '{2'b11, 2'b00, 2'b11, 5'h03, 5'h0C, 32'h1111_0000, 32'h2222_000C, 2'b10, 2'b10, 1'b1, 1'b0, 5'h0C, 32'h2222_000C, 32'h0};
    vecs[13] = '{2'b01, 2'b01, 2'b00, 5'h08, 5'h0C, 32'h5555_0000, 32'h2222_000C, 2'b01, 2'b01, 1'b0, 1'b1, 5'h08, 32'h5555_0000, 32'hDEAD_BEEF};
    vecs[14] = '{2'b10, 2'b01, 2'b10, 5'h08, 5'h0C, 32'h5555_0000, 32'h2222_000C, 2'b00, 2'b00, 1'b0, 1'b0, 5'h08, 32'h5555_0000, 32'h0};
    vecs[15] = '{2'b10, 2'b00, 2'b10, 5'h08, 5'h0C, 32'h5555_0000, 32'h2222_000C, 2'b10, 2'b10, 1'b1, 1'b0, 5'h0C, 32'h2222_000C, 32'h0};
    vecs[16] = '{2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 5'h0C, 32'h2222_000C, 32'h0};

    // Reset: outputs cleared, gnt still follows req, nothing accepted
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(rq.ack), 32'h0);
    chk("rst_s_we", 32'(bus.s_we), 32'h0);
    chk("rst_s_re", 32'(bus.s_re), 32'h0);
    chk("rst_s_addr", 32'(bus.s_addr), 32'h0);
    chk("rst_s_wd", 32'(bus.s_wd), 32'h0);
    chk("rst_gnt_idle", 32'(rq.gnt), 32'h0);
    @(negedge clk);
    drive(2'b11, 2'b00, 2'b11, 5'h1F, 5'h1E, 32'hFFFF_FFFF, 32'hEEEE_EEEE);
    #1;
    chk("rst_gnt_follows", 32'(rq.gnt), 32'h1);
    @(posedge clk);
    #1;
    chk("rst_no_accept_ack", 32'(rq.ack), 32'h0);
    chk("rst_no_accept_we", 32'(bus.s_we), 32'h0);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    rstn = 1'b1;
    #1;
    chk("idle_gnt", 32'(rq.gnt), 32'h0);

    // Table-driven directed vectors
    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      drive(vecs[v].req, vecs[v].lock, vecs[v].we, vecs[v].a0, vecs[v].a1, vecs[v].d0, vecs[v].d1);
      #1;
      chk($sformatf("v%0d_gnt", v), 32'(rq.gnt), 32'(vecs[v].gnt));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ack", v), 32'(rq.ack), 32'(vecs[v].ack));
      chk($sformatf("v%0d_s_we", v), 32'(bus.s_we), 32'(vecs[v].s_we));
      chk($sformatf("v%0d_s_re", v), 32'(bus.s_re), 32'(vecs[v].s_re));
      chk($sformatf("v%0d_s_addr", v), 32'(bus.s_addr), 32'(vecs[v].s_addr));
      chk($sformatf("v%0d_s_wd", v), bus.s_wd, vecs[v].s_wd);
      if (vecs[v].s_re) chk($sformatf("v%0d_rdata", v), rq.rdata, vecs[v].rd);
    end

    // Reset asserted in the middle of an ack cycle
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b01, 5'h10, 5'h00, 32'h99, 32'h0);
    #1;
    chk("mid_gnt", 32'(rq.gnt), 32'h1);
    @(posedge clk);
    #1;
    chk("mid_ack_before", 32'(rq.ack), 32'h1);
    chk("mid_we_before", 32'(bus.s_we), 32'h1);
    rstn = 1'b0;
    #1;
    chk("mid_ack_dropped", 32'(rq.ack), 32'h0);
    chk("mid_we_dropped", 32'(bus.s_we), 32'h0);
    chk("mid_re_dropped", 32'(bus.s_re), 32'h0);
    chk("mid_addr_cleared", 32'(bus.s_addr), 32'h0);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    rstn = 1'b1;

    // Randomized phase against the behavioural model
    m_ptr = 0; m_owner = 0; m_locked = 0; m_saddr = '0; m_swd = '0;
    cr = '0; cl = '0; cw = '0;
    for (int i = 0; i < 2; i++) begin ca[i] = '0; cd[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      int  win;
      bit  held;
      logic [1:0] exp_gnt;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        // A pending request keeps its command stable until it is granted.
        if (!cr[i]) begin
          cr[i] = ($urandom_range(0, 2) != 0);
          cw[i] = 1'($urandom);
          ca[i] = AW'($urandom);
          cd[i] = $urandom;
        end
        cl[i] = ($urandom_range(0, 3) == 0);
      end
      drive(cr, cl, cw, ca[0], ca[1], cd[0], cd[1]);

      held = m_locked && cl[m_owner];
      win  = -1;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (win < 0 && cr[i] && (!held || i == m_owner)) win = i;
      end
      exp_gnt = (win >= 0) ? 2'(1 << win) : 2'b00;

      #1;
      chk($sformatf("r%0d_gnt", c), 32'(rq.gnt), 32'(exp_gnt));
      @(posedge clk);
      #1;
      if (win >= 0) begin
        m_saddr = ca[win];
        m_swd   = cd[win];
        if (cl[win]) begin
          m_locked = 1;
          m_owner  = win;
        end else begin
          m_locked = 0;
          m_ptr    = (win + 1) % NREQ;
        end
      end else begin
        m_locked = held;
      end
      chk($sformatf("r%0d_ack", c), 32'(rq.ack), 32'(exp_gnt));
      chk($sformatf("r%0d_s_we", c), 32'(bus.s_we), 32'(win >= 0 && cw[win]));
      chk($sformatf("r%0d_s_re", c), 32'(bus.s_re), 32'(win >= 0 && !cw[win]));
      chk($sformatf("r%0d_s_addr", c), 32'(bus.s_addr), 32'(m_saddr));
      chk($sformatf("r%0d_s_wd", c), bus.s_wd, m_swd);
      chk($sformatf("r%0d_rdata", c), rq.rdata, slave_rd(m_saddr));
      if (win >= 0) cr[win] = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
